// File: rtl/rom_pkg.sv
// Shared definitions for the lookup-ROM read path.
//   ADDR_W / DATA_W : ROM geometry ({bank[1:0], idx[2:0]} x 8-bit BCD entries)
//   BANK_A/B/C      : the three populated table banks (bank 00 is unused)
//   MAX_LEN         : longest legal burst (one full table)
//   state_e         : burst reader FSM states
//   req_legal()     : request legality check used at accept time
package rom_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 8;

  localparam logic [1:0] BANK_A = 2'b01;
  localparam logic [1:0] BANK_B = 2'b10;
  localparam logic [1:0] BANK_C = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_ERR
  } state_e;

  function automatic logic req_legal(input logic [1:0] bank, input logic [3:0] len);
    return (bank inside {BANK_A, BANK_B, BANK_C}) && (len != 4'd0) && (int'(len) <= MAX_LEN);
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Output buffer for the burst reader: synchronous FIFO holding {last, data}.
//   clk, reset     : clock, async active-low reset (clears pointers and count)
//   push/push_data : write strobe and entry
//   pop            : consume head entry
//   head_data      : current head entry (valid while !empty)
//   count          : number of stored entries
//   empty          : no entries stored
module rom_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The reader's credit scheme must never let a write land on a full buffer.
  overflow_chk: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop))
    else $error("rom_rd_fifo: write into full buffer");

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read controller for the 32x8 lookup ROM.
//   clk, reset              : clock, async active-low reset
//   req_valid/req_ready     : burst request handshake (ready only in IDLE)
//   req_bank/start/len      : table bank, first index, entry count (1..8)
//   rom_addr / rom_data     : registered ROM address, ROM output (1-cycle latency)
//   out_valid/ready/data/last : entry stream to the consumer
//   busy                    : request accepted, last entry not yet consumed
//   err                     : one-cycle pulse on an illegal request
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready high
// ST_ISSUE | issuing ROM addresses, limited by free buffer credit
// ST_DRAIN | all addresses issued, waiting for the last entry to be popped
// ST_ERR   | illegal request seen, err pulses for this one cycle
module rom_burst_reader #(
  parameter int ADDR_W     = rom_pkg::ADDR_W,
  parameter int DATA_W     = rom_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_bank,
  input  logic [2:0]        req_start,
  input  logic [3:0]        req_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  import rom_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state;
  logic [1:0]        bank_q;
  logic [2:0]        idx_q;
  logic [3:0]        rem_q;
  // s1: address issued last edge; s2: rom_data valid now. l1/l2 carry the last flag.
  logic              s1, s2, l1, l2;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              pop;

  // Entries in flight count against the buffer so the ROM never outruns it.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1} + {{CW{1'b0}}, s2};
  assign issue     = (state == ST_ISSUE) && (rem_q != 4'd0) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head[DATA_W-1:0] : '0;
  assign out_last  = out_valid && fifo_head[DATA_W];

  rom_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s2),
    .push_data ({l2, rom_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bank_q    <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      rom_addr  <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      s1  <= issue;
      l1  <= issue && (rem_q == 4'd1);
      s2  <= s1;
      l2  <= l1;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            bank_q    <= req_bank;
            idx_q     <= req_start;
            rem_q     <= req_len;
            req_ready <= 1'b0;
            if (req_legal(req_bank, req_len)) begin
              state <= ST_ISSUE;
              busy  <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            rom_addr <= ADDR_W'({bank_q, idx_q});
            idx_q    <= idx_q + 3'd1;  // wraps inside the selected bank
            rem_q    <= rem_q - 4'd1;
            if (rem_q == 4'd1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1 && !s2 && pop && out_last) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        ST_ERR: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed and randomized-backpressure bench for rom_burst_reader with a
// registered-read ROM model.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_bank;
  logic [2:0] req_start;
  logic [3:0] req_len;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  rom_burst_reader dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_bank  (req_bank),
    .req_start (req_start),
    .req_len   (req_len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [4:0] a);
    logic [63:0] row;
    int i;
    case (a[4:3])
      2'b01:   row = 64'h2118151209060300;
      2'b10:   row = 64'h1210090807050300;
      2'b11:   row = 64'h0908070605040300;
      default: row = 64'hEEEEEEEEEEEEEEEE;
    endcase
    i = int'(a[2:0]);
    return row[8*i +: 8];
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one request on the current negedge; returns at the next negedge.
  task automatic send_req(input logic [1:0] bank, input logic [2:0] start, input logic [3:0] len);
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_bank  = bank;
    req_start = start;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // mode 0: ready always high; 1: ready low for 10 cycles after first beat; 2: random ready
  task automatic collect(input logic [1:0] bank, input logic [2:0] start, input int len, input int mode);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    logic [2:0] idx = start;
    logic stalling;
    while (k < len && cyc < 300) begin
      stalling = (mode == 1) && (k >= 1) && (stall < 10);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !stalling;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalling) begin
        stall++;
        if (stall == 10) begin
          chk("stall_addr", rom_addr, {bank, start + 3'd4});
          chk("stall_valid", out_valid, 1);
        end
      end
      if (mode == 0 && k > 0) chk("stream_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        chk("data", out_data, rom_val({bank, idx}));
        chk("last", out_last, (k == len - 1));
        idx = idx + 3'd1;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("beats", k, len);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int cyc;
    logic [4:0] prev_addr;
    logic [1:0] b;
    logic [2:0] s;
    logic [3:0] l;

    reset = 1'b0; req_valid = 1'b0; req_bank = '0; req_start = '0; req_len = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr", rom_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);

    // Full bank 01 table, latency and streaming.
    send_req(2'b01, 3'd0, 4'd8);
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", req_ready, 0);
    chk("t1_valid_n1", out_valid, 0);
    @(negedge clk);
    chk("t1_addr0", rom_addr, 5'b01000);
    chk("t1_valid_n2", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_n3", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_n4", out_valid, 1);
    collect(2'b01, 3'd0, 8, 0);
    chk("t1_ready_end", req_ready, 1);

    // Index wrap inside bank 10.
    send_req(2'b10, 3'd6, 4'd4);
    @(negedge clk);
    chk("t2_addr0", rom_addr, 5'b10110);
    @(negedge clk);
    chk("t2_addr1", rom_addr, 5'b10111);
    @(negedge clk);
    chk("t2_addr2", rom_addr, 5'b10000);
    collect(2'b10, 3'd6, 4, 0);
    chk("t2_addr_hold", rom_addr, 5'b10001);

    // Backpressure: consumer stalls after first beat.
    send_req(2'b11, 3'd0, 4'd8);
    collect(2'b11, 3'd0, 8, 1);

    // Illegal requests.
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin b = 2'b00; l = 4'd3; end
        1:       begin b = 2'b01; l = 4'd0; end
        default: begin b = 2'b01; l = 4'd9; end
      endcase
      prev_addr = rom_addr;
      send_req(b, 3'd0, l);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_ready", req_ready, 1);
      chk("err_no_valid", out_valid, 0);
      chk("err_addr", rom_addr, prev_addr);
    end

    // Reset in the middle of a burst.
    send_req(2'b01, 3'd0, 4'd8);
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 50) begin
      if (out_valid && out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_beats", k, 3);
    reset = 1'b0;
    #1;
    chk("rst_mid_addr", rom_addr, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_last", out_last, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_req(2'b11, 3'd2, 4'd2);
    collect(2'b11, 3'd2, 2, 0);

    // Back-to-back legal requests under random backpressure.
    for (int r = 0; r < 200; r++) begin
      b = 2'($urandom_range(1, 3));
      s = 3'($urandom_range(0, 7));
      l = 4'($urandom_range(1, 8));
      send_req(b, s, l);
      collect(b, s, int'(l), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
